// File: rtl/fake_n64_controller_rx.sv
`timescale 1ns/1ps
// Joybus receive front-end of the fake N64 controller: oversamples the console's line,
// frames command/address/WRITE payload (with CRC-8) and hands the bus to the tx stage.
module fake_n64_controller_rx #(
    parameter int LEVEL_WIDTH  = 2,
    parameter int SAMPLE_POINT = 2 * LEVEL_WIDTH,
    parameter int BIT_CLKS     = 4 * LEVEL_WIDTH,
    parameter int IDLE_TIMEOUT = 4 * BIT_CLKS
) (
    input  logic        sample_clk,
    input  logic        reset_n,
    input  logic        data_rx,
    input  logic        rx_handoff,
    output logic        cur_operation,
    output logic [7:0]  cmd,
    output logic [15:0] addr,
    output logic [7:0]  crc,
    output logic        frame_error
);

    localparam int SCW = $clog2(BIT_CLKS + 2);
    localparam int HCW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [SCW-1:0] SMP_MAX  = {SCW{1'b1}};
    localparam logic [HCW-1:0] HIGH_MAX = HCW'(IDLE_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_WAIT_HIGH,
        S_WAIT_FALL,
        S_HANDOFF,
        S_DISCARD
    } state_t;

    state_t         state, state_nxt;
    logic           sync_1, sync_2, sync_d;
    logic           handoff_q;
    logic [SCW-1:0] smp_cnt;
    logic [HCW-1:0] high_cnt;
    logic [8:0]     bit_cnt;
    logic [7:0]     cmd_sh;
    logic [15:0]    addr_sh;
    logic [7:0]     crc_sh;

    logic           fall, toggle, sample_now, smp_late, high_done;
    logic [8:0]     frame_len;
    logic           frame_start, shift_bit, commit, err_nxt;

    // Total decoded bits before the stop bit; zero marks an unsupported command.
    function automatic logic [8:0] len_of(input logic [7:0] c);
        case (c)
            8'h00, 8'hFF, 8'h01: len_of = 9'd8;
            8'h02:               len_of = 9'd24;
            8'h03:               len_of = 9'd280;
            default:             len_of = 9'd0;
        endcase
    endfunction

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic d);
        crc_step = {c[6:0], 1'b0} ^ ((c[7] ^ d) ? 8'h85 : 8'h00);
    endfunction

    assign fall          = sync_d & ~sync_2;
    assign toggle        = handoff_q ^ rx_handoff;
    assign frame_len     = len_of(cmd_sh);
    assign sample_now    = (smp_cnt == SCW'(SAMPLE_POINT));
    assign smp_late      = (smp_cnt > SCW'(BIT_CLKS));
    assign high_done     = sync_2 && (high_cnt >= HCW'(IDLE_TIMEOUT - 1));
    assign cur_operation = (state == S_HANDOFF);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1    <= 1'b1;
            sync_2    <= 1'b1;
            sync_d    <= 1'b1;
            handoff_q <= 1'b0;
            smp_cnt   <= '0;
            high_cnt  <= '0;
        end else begin
            sync_1    <= data_rx;
            sync_2    <= sync_1;
            sync_d    <= sync_2;
            handoff_q <= rx_handoff;
            if (fall)
                smp_cnt <= SCW'(1);
            else if (smp_cnt != SMP_MAX)
                smp_cnt <= smp_cnt + SCW'(1);
            if (!sync_2)
                high_cnt <= '0;
            else if (high_cnt != HIGH_MAX)
                high_cnt <= high_cnt + HCW'(1);
        end
    end

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        shift_bit   = 1'b0;
        commit      = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall) begin
                    frame_start = 1'b1;
                    state_nxt   = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (sample_now) begin
                    if (bit_cnt < 9'd8) begin
                        shift_bit = 1'b1;
                        state_nxt = S_WAIT_HIGH;
                    end else if (frame_len == 9'd0) begin
                        state_nxt = S_DISCARD;
                    end else if (bit_cnt == frame_len) begin
                        if (sync_2) begin
                            commit    = 1'b1;
                            state_nxt = S_HANDOFF;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = S_DISCARD;
                        end
                    end else begin
                        shift_bit = 1'b1;
                        state_nxt = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (sync_2) begin
                    state_nxt = S_WAIT_FALL;
                end else if (smp_late) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_DISCARD;
                end
            end
            S_WAIT_FALL: begin
                if (fall) begin
                    state_nxt = S_SAMPLE;
                end else if (high_done) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_HANDOFF: begin
                if (toggle) state_nxt = S_IDLE;
            end
            S_DISCARD: begin
                if (high_done) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Shadow registers collect the frame; the visible outputs only change on commit,
    // so an aborted frame never disturbs what the tx stage is looking at.
    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt     <= '0;
            cmd_sh      <= '0;
            addr_sh     <= '0;
            crc_sh      <= '0;
            cmd         <= '0;
            addr        <= '0;
            crc         <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= err_nxt;
            if (frame_start) begin
                bit_cnt <= '0;
                cmd_sh  <= '0;
                addr_sh <= '0;
                crc_sh  <= '0;
            end else if (shift_bit) begin
                bit_cnt <= bit_cnt + 9'd1;
                if (bit_cnt < 9'd8)
                    cmd_sh <= {cmd_sh[6:0], sync_2};
                else if (bit_cnt < 9'd24)
                    addr_sh <= {addr_sh[14:0], sync_2};
                else
                    crc_sh <= crc_step(crc_sh, sync_2);
            end
            if (commit) begin
                cmd  <= cmd_sh;
                addr <= addr_sh;
                crc  <= crc_sh;
            end
        end
    end

endmodule

// File: tb/tb_fake_n64_controller_rx.sv
`timescale 1ns/1ps
// Self-checking bench for fake_n64_controller_rx: console-side Joybus frame generator
// plus a frame-level reference model of the expected handoff outputs.
module tb_fake_n64_controller_rx;

    localparam int LW      = 2;
    localparam int SP      = 2 * LW;
    localparam int BC      = 4 * LW;
    localparam int IT      = 4 * BC;
    localparam int EXP_LAT = 2 + SP + 1;

    logic        sample_clk = 1'b0;
    logic        reset_n    = 1'b0;
    logic        data_rx    = 1'b1;
    logic        rx_handoff = 1'b0;
    logic        cur_operation;
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [7:0]  crc;
    logic        frame_error;

    int checks   = 0;
    int failures = 0;
    int fe_count = 0;
    int co_count = 0;

    logic [7:0]  exp_cmd  = 8'h00;
    logic [15:0] exp_addr = 16'h0000;
    logic [7:0]  exp_crc  = 8'h00;

    fake_n64_controller_rx #(
        .LEVEL_WIDTH (LW),
        .SAMPLE_POINT(SP),
        .BIT_CLKS    (BC),
        .IDLE_TIMEOUT(IT)
    ) dut (
        .sample_clk   (sample_clk),
        .reset_n      (reset_n),
        .data_rx      (data_rx),
        .rx_handoff   (rx_handoff),
        .cur_operation(cur_operation),
        .cmd          (cmd),
        .addr         (addr),
        .crc          (crc),
        .frame_error  (frame_error)
    );

    always #5 sample_clk = ~sample_clk;

    always @(posedge sample_clk) begin
        if (frame_error === 1'b1)   fe_count++;
        if (cur_operation === 1'b1) co_count++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Reference: frame length in bits from the command byte, 0 = unsupported.
    function automatic int frame_bits(input logic [7:0] c);
        case (c)
            8'h00, 8'hFF, 8'h01: return 8;
            8'h02:               return 24;
            8'h03:               return 280;
            default:             return 0;
        endcase
    endfunction

    // Reference CRC-8 (poly 0x85, init 0) over the 256-bit payload, first byte first.
    function automatic logic [7:0] crc_model(input logic [255:0] pay);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 255; i >= 0; i--) begin
            fb = c[7] ^ pay[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h85;
        end
        return c;
    endfunction

    task automatic drive(input logic v, input int n);
        data_rx = v;
        repeat (n) @(negedge sample_clk);
    endtask

    task automatic idle(input int n);
        drive(1'b1, n);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            drive(1'b0, LW);
            drive(1'b1, 3 * LW);
        end else begin
            drive(1'b0, 3 * LW);
            drive(1'b1, LW);
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    // Stop bit (one low quarter then high); returns clocks until cur_operation rose, -1 if never.
    task automatic send_stop(output int lat);
        lat     = -1;
        data_rx = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge sample_clk);
            if (k == LW) data_rx = 1'b1;
            if (cur_operation === 1'b1 && lat < 0) lat = k;
        end
    endtask

    task automatic run_frame(input logic [7:0] c, input logic [15:0] a,
                             input logic [255:0] pay, input string tag);
        int nbits;
        int lat;
        int fe0;
        int exp_lat;
        nbits = frame_bits(c);
        fe0   = fe_count;
        send_byte(c);
        if (nbits >= 24) begin
            send_byte(a[15:8]);
            send_byte(a[7:0]);
        end
        if (nbits == 280)
            for (int i = 31; i >= 0; i--) send_byte(pay[i*8 +: 8]);
        send_stop(lat);

        if (nbits != 0) begin
            exp_cmd = c;
            exp_crc = (c == 8'h03) ? crc_model(pay) : 8'h00;
            if (nbits >= 24) exp_addr = a;
            exp_lat = EXP_LAT;
        end else begin
            exp_lat = -1;
        end

        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL %s handoff_latency: got %0d expected %0d", tag, lat, exp_lat);
        end
        checks++;
        if (cmd !== exp_cmd) begin
            failures++;
            $display("FAIL %s cmd: got %h expected %h", tag, cmd, exp_cmd);
        end
        checks++;
        if (crc !== exp_crc) begin
            failures++;
            $display("FAIL %s crc: got %h expected %h", tag, crc, exp_crc);
        end
        if (nbits >= 24) begin
            checks++;
            if (addr !== exp_addr) begin
                failures++;
                $display("FAIL %s addr: got %h expected %h", tag, addr, exp_addr);
            end
        end
        checks++;
        if (fe_count !== fe0) begin
            failures++;
            $display("FAIL %s frame_error_cycles: got %0d expected 0", tag, fe_count - fe0);
        end

        if (nbits != 0) begin
            checks++;
            if (cur_operation !== 1'b1) begin
                failures++;
                $display("FAIL %s handoff_held: got %b expected 1", tag, cur_operation);
            end
            rx_handoff = ~rx_handoff;
            @(negedge sample_clk);
            checks++;
            if (cur_operation !== 1'b0) begin
                failures++;
                $display("FAIL %s handoff_release: got %b expected 0", tag, cur_operation);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (4) @(negedge sample_clk);
        checks++;
        if ({cur_operation, cmd, addr, crc, frame_error} !== 34'd0) begin
            failures++;
            $display("FAIL reset_values: got op=%b cmd=%h addr=%h crc=%h fe=%b expected all zero",
                     cur_operation, cmd, addr, crc, frame_error);
        end
        reset_n = 1'b1;
        idle(4);
    endtask

    task automatic test_basic_commands();
        run_frame(8'h01, 16'h0000, 256'h0, "cmd01");
        run_frame(8'h02, 16'h8001, 256'h0, "read_8001");
        run_frame(8'h03, 16'h0000, 256'h1, "write_crc85");
        run_frame(8'h03, 16'h0000, 256'h0, "write_crc00");
    endtask

    task automatic test_random_frames();
        logic [7:0]   pool [5];
        logic [255:0] pay;
        pool = '{8'h00, 8'hFF, 8'h01, 8'h02, 8'h03};
        for (int n = 0; n < 6; n++) begin
            for (int w = 0; w < 8; w++) pay[w*32 +: 32] = $urandom;
            run_frame(pool[$urandom_range(0, 4)], 16'($urandom), pay, $sformatf("random%0d", n));
        end
    endtask

    task automatic test_discard();
        int co0;
        co0 = co_count;
        run_frame(8'h40, 16'h0000, 256'h0, "discard40");
        idle(IT);
        checks++;
        if (co_count !== co0) begin
            failures++;
            $display("FAIL discard_no_handoff: got %0d cycles expected 0", co_count - co0);
        end
        run_frame(8'h00, 16'h0000, 256'h0, "after_discard00");
    endtask

    task automatic test_error();
        int fe0;
        int co0;
        // Bit 3 held low far beyond a bit cell.
        fe0 = fe_count;
        co0 = co_count;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        drive(1'b0, 20);
        idle(IT + 16);
        checks++;
        if (fe_count - fe0 !== 1) begin
            failures++;
            $display("FAIL stuck_low_error_pulse: got %0d cycles expected 1", fe_count - fe0);
        end
        checks++;
        if (co_count !== co0 || cmd !== exp_cmd || crc !== exp_crc) begin
            failures++;
            $display("FAIL stuck_low_outputs: got op_cycles=%0d cmd=%h crc=%h expected 0 %h %h",
                     co_count - co0, cmd, crc, exp_cmd, exp_crc);
        end
        // Stop bit sampled low.
        fe0 = fe_count;
        co0 = co_count;
        send_byte(8'h01);
        send_bit(1'b0);
        idle(IT + 16);
        checks++;
        if (fe_count - fe0 !== 1) begin
            failures++;
            $display("FAIL bad_stop_error_pulse: got %0d cycles expected 1", fe_count - fe0);
        end
        checks++;
        if (co_count !== co0 || cmd !== exp_cmd) begin
            failures++;
            $display("FAIL bad_stop_outputs: got op_cycles=%0d cmd=%h expected 0 %h",
                     co_count - co0, cmd, exp_cmd);
        end
        run_frame(8'h01, 16'h0000, 256'h0, "after_error01");
    endtask

    task automatic test_back_to_back();
        run_frame(8'h02, 16'($urandom), 256'h0, "b2b_read");
        run_frame(8'hFF, 16'h0000, 256'h0, "b2b_ff");
        run_frame(8'h02, 16'h1234, 256'h0, "b2b_read2");
    endtask

    task automatic test_reset_midframe();
        run_frame(8'h03, 16'hBEEF, 256'h1, "pre_reset_write");
        send_byte(8'h02);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        data_rx = 1'b0;
        repeat (2) @(negedge sample_clk);
        reset_n = 1'b0;
        #1;
        exp_cmd  = 8'h00;
        exp_addr = 16'h0000;
        exp_crc  = 8'h00;
        checks++;
        if ({cur_operation, cmd, addr, crc, frame_error} !== 34'd0) begin
            failures++;
            $display("FAIL midframe_reset: got op=%b cmd=%h addr=%h crc=%h fe=%b expected all zero",
                     cur_operation, cmd, addr, crc, frame_error);
        end
        @(negedge sample_clk);
        data_rx = 1'b1;
        reset_n = 1'b1;
        idle(IT);
        run_frame(8'h00, 16'h0000, 256'h0, "post_reset00");
    endtask

    initial begin
        test_reset();
        test_basic_commands();
        test_random_frames();
        test_discard();
        test_error();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
